// File: rtl/tone_gen_pkg.sv
// Shared widths and FSM encoding for the note player and the arithmetic stage feeding it.
package tone_gen_pkg;

    localparam int NOTE_W = 8;
    localparam int DUR_W  = 8;
    // One extra bit so a duration code of 0 can hold the value 256.
    localparam int DCNT_W = DUR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [DCNT_W-1:0] dur_load(input logic [DUR_W-1:0] d);
        return (d == '0) ? {1'b1, {DUR_W{1'b0}}} : {1'b0, d};
    endfunction

endpackage

// File: rtl/tone_gen_tick_div.sv
// Modulo-N counter with synchronous clear; o_tick is high on the last count of each wrap.
// Latency: o_tick is combinational from the count; no backpressure.
module tick_div #(
    parameter int N = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [W-1:0] r_cnt;

    assign o_tick = (r_cnt == W'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + W'(1);
        end
    end

endmodule

// File: rtl/tone_gen.sv
// Plays one note per accepted byte as a square wave, then a fixed silent gap; done pulses as the gap ends.
// Latency: speaker first rises PRESCALE*note cycles after accept; note_ready is low for the whole PLAY+GAP.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int PRESCALE  = 250,
    parameter int DUR_DIV   = 50000,
    parameter int GAP_UNITS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [DUR_W-1:0]  dur_in,
    input  logic              note_valid,
    output logic              note_ready,
    output logic              speaker,
    output logic              busy,
    output logic              done
);

    localparam logic [NOTE_W-1:0] NOTE_ONE = NOTE_W'(1);
    localparam logic [DCNT_W-1:0] DCNT_ONE = DCNT_W'(1);
    localparam logic [DCNT_W-1:0] GAP_LOAD = DCNT_W'(GAP_UNITS);

    state_t              r_state;
    logic [NOTE_W-1:0]   r_note;
    logic [NOTE_W-1:0]   r_half_cnt;
    logic [DCNT_W-1:0]   r_dur_cnt;
    logic                r_speaker;
    logic                r_busy;
    logic                r_done;
    logic                r_note_ready;

    logic                w_tick;
    logic                w_dtick;
    logic                w_pres_clr;
    logic                w_div_clr;
    logic                w_accept;

    // Holding the dividers in clear outside their active states means they start at 0 on entry.
    assign w_pres_clr = (r_state != ST_PLAY);
    assign w_div_clr  = (r_state == ST_IDLE);
    assign w_accept   = note_valid && r_note_ready;

    tick_div #(.N(PRESCALE)) u_pres_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_pres_clr),
        .o_tick (w_tick)
    );

    tick_div #(.N(DUR_DIV)) u_dur_div (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_div_clr),
        .o_tick (w_dtick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_note       <= '0;
            r_half_cnt   <= '0;
            r_dur_cnt    <= '0;
            r_speaker    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_note_ready <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_speaker <= 1'b0;
                    if (w_accept) begin
                        r_note       <= note_in;
                        r_dur_cnt    <= dur_load(dur_in);
                        r_half_cnt   <= note_in - NOTE_ONE;
                        r_state      <= ST_PLAY;
                        r_busy       <= 1'b1;
                        r_note_ready <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (w_tick && (r_note != '0)) begin
                        if (r_half_cnt == '0) begin
                            r_speaker  <= ~r_speaker;
                            r_half_cnt <= r_note - NOTE_ONE;
                        end else begin
                            r_half_cnt <= r_half_cnt - NOTE_ONE;
                        end
                    end
                    // Written after the tone update so end-of-note silences a coincident toggle.
                    if (w_dtick) begin
                        if (r_dur_cnt == DCNT_ONE) begin
                            r_state   <= ST_GAP;
                            r_speaker <= 1'b0;
                            r_dur_cnt <= GAP_LOAD;
                        end else begin
                            r_dur_cnt <= r_dur_cnt - DCNT_ONE;
                        end
                    end
                end
                ST_GAP: begin
                    r_speaker <= 1'b0;
                    if (w_dtick) begin
                        if (r_dur_cnt == DCNT_ONE) begin
                            r_state      <= ST_IDLE;
                            r_done       <= 1'b1;
                            r_busy       <= 1'b0;
                            r_note_ready <= 1'b1;
                        end else begin
                            r_dur_cnt <= r_dur_cnt - DCNT_ONE;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_speaker    <= 1'b0;
                    r_busy       <= 1'b0;
                    r_note_ready <= 1'b1;
                end
            endcase
        end
    end

    assign note_ready = r_note_ready;
    assign speaker    = r_speaker;
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
